// File: rtl/psram_ctrl_pkg.sv
// psram_ctrl_pkg: shared states, command codes, phase lengths and size helpers for psram_ctrl
package psram_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_DONE} state_e;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_QREAD = 8'hEB;
  localparam logic [4:0] CMD_EDGES = 5'd8;
  localparam logic [4:0] ADDR_EDGES = 5'd6;
  localparam logic [1:0] SZ_1B = 2'd0;
  localparam logic [1:0] SZ_2B = 2'd1;
  localparam logic [1:0] SZ_4B = 2'd2;
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    return 3'd1 << size;
  endfunction
  function automatic logic size_legal(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_4B ? lane == 2'd0 : size == SZ_2B ? !lane[0] : size == SZ_1B;
  endfunction
endpackage

// File: rtl/psram_ctrl_shift.sv
// psram_ctrl_shift: 32-bit nibble shift register; loads bus lanes in address order, shifts nibbles out/in, unpacks read bytes to lanes
module psram_ctrl_shift (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  nbytes_i,
  input  logic        shift_out_i,
  input  logic        shift_in_i,
  input  logic [3:0]  din_i,
  output logic [3:0]  nib_o,
  output logic [31:0] word_o
);
  logic [31:0] sr_q, sr_d, ld;
  logic [1:0] lane_q;
  logic [2:0] nb_q;
  always_comb begin
    ld = '0;
    word_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(nbytes_i)) ld[{2'(3 - i), 3'b000} +: 8] = wdata_i[{lane_i + 2'(i), 3'b000} +: 8];
      if (i < int'(nb_q)) word_o[{lane_q + 2'(i), 3'b000} +: 8] = sr_q[{2'(int'(nb_q) - 1 - i), 3'b000} +: 8];
    end
  end
  assign sr_d = load_i ? ld : (shift_out_i | shift_in_i) ? {sr_q[27:0], shift_in_i ? din_i : 4'h0} : sr_q;
  assign nib_o = sr_q[31:28];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
      lane_q <= '0;
      nb_q <= '0;
    end else begin
      sr_q <= sr_d;
      if (load_i) begin
        lane_q <= lane_i;
        nb_q <= nbytes_i;
      end
    end
  end
endmodule

// File: rtl/psram_ctrl.sv
// psram_ctrl: QPI PSRAM master turning 1/2/4-byte requests into cmd/addr/data frames on sck, ce_n, dio
module psram_ctrl
  import psram_ctrl_pkg::*;
#(
  parameter int DUMMY_EDGES = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        sck,
  output logic        ce_n,
  output logic [3:0]  dio_o,
  output logic        dio_oe,
  input  logic [3:0]  dio_i
);
  state_e state_q;
  logic [4:0] cnt_q, last_edge;
  logic sck_q, ce_n_q, oe_q, we_q, err_q;
  logic [3:0] dio_q, nib;
  logic [2:0] nb_q;
  logic [7:0] cmd_q, cmd_w;
  logic [23:0] addr_q;
  logic [31:0] word;
  logic fall, end_ph, legal, shift_out, shift_in;
  assign legal = size_legal(req_size, req_addr[1:0]);
  assign cmd_w = req_we ? CMD_QWRITE : CMD_QREAD;
  assign fall = ~ce_n_q & sck_q;
  always_comb begin
    last_edge = state_q == S_CMD ? CMD_EDGES - 5'd1 : state_q == S_ADDR ? ADDR_EDGES - 5'd1 :
                state_q == S_DUMMY ? 5'(DUMMY_EDGES - 1) : {1'b0, nb_q, 1'b0} - 5'd1;
  end
  assign end_ph = fall & (cnt_q == last_edge);
  assign shift_out = fall & we_q & ((state_q == S_ADDR & end_ph) | (state_q == S_WDATA & ~end_ph));
  assign shift_in = fall & (state_q == S_RDATA);
  psram_ctrl_shift u_shift (
    .clk_i(clock),
    .rst_i(reset),
    .load_i(req_ready & req_valid & legal),
    .wdata_i(req_wdata),
    .lane_i(req_addr[1:0]),
    .nbytes_i(size_bytes(req_size)),
    .shift_out_i(shift_out),
    .shift_in_i(shift_in),
    .din_i(dio_i),
    .nib_o(nib),
    .word_o(word)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sck_q <= 1'b0;
      ce_n_q <= 1'b1;
      dio_q <= '0;
      oe_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      nb_q <= '0;
      cmd_q <= '0;
      addr_q <= '0;
    end else begin
      if (!ce_n_q) sck_q <= ~sck_q;
      if (fall) cnt_q <= end_ph ? '0 : cnt_q + 5'd1;
      case (state_q)
        S_IDLE: if (req_valid) begin
          we_q <= req_we;
          nb_q <= size_bytes(req_size);
          err_q <= !legal;
          state_q <= legal ? S_CMD : S_DONE;
          if (legal) begin
            ce_n_q <= 1'b0;
            oe_q <= 1'b1;
            dio_q <= {3'b000, cmd_w[7]};
            cmd_q <= {cmd_w[6:0], 1'b0};
            addr_q <= req_addr;
          end
        end
        S_CMD: if (fall) begin
          dio_q <= end_ph ? addr_q[23:20] : {3'b000, cmd_q[7]};
          if (end_ph) begin
            state_q <= S_ADDR;
            addr_q <= {addr_q[19:0], 4'h0};
          end else cmd_q <= {cmd_q[6:0], 1'b0};
        end
        S_ADDR: if (fall) begin
          if (end_ph) begin
            state_q <= we_q ? S_WDATA : S_DUMMY;
            oe_q <= we_q;
            dio_q <= we_q ? nib : 4'h0;
          end else begin
            dio_q <= addr_q[23:20];
            addr_q <= {addr_q[19:0], 4'h0};
          end
        end
        S_WDATA: if (fall) begin
          dio_q <= end_ph ? 4'h0 : nib;
          if (end_ph) begin
            state_q <= S_DONE;
            ce_n_q <= 1'b1;
            oe_q <= 1'b0;
          end
        end
        S_DUMMY: if (end_ph) state_q <= S_RDATA;
        S_RDATA: if (end_ph) begin
          state_q <= S_DONE;
          ce_n_q <= 1'b1;
        end
        S_DONE: if (resp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign req_ready = (state_q == S_IDLE) & ~reset;
  assign resp_valid = state_q == S_DONE;
  assign resp_err = resp_valid & err_q;
  assign resp_rdata = (resp_valid & ~we_q & ~err_q) ? word : '0;
  assign sck = sck_q;
  assign ce_n = ce_n_q;
  assign dio_o = dio_q;
  assign dio_oe = oe_q;
endmodule

// File: tb/tb_psram_ctrl.sv
// tb_psram_ctrl: vector table, corner sequences and random requests against a PSRAM device model and byte-level reference
module tb_psram_ctrl;
  localparam int D = 6;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, req_valid, req_we, resp_ready, resp_valid, req_ready, resp_err, sck, ce_n, dio_oe;
  logic [23:0] req_addr;
  logic [1:0] req_size;
  logic [31:0] req_wdata, resp_rdata;
  logic [3:0] dio_o;
  logic [3:0] dio_i = 4'h0;
  psram_ctrl #(.DUMMY_EDGES(D)) dut (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .sck(sck), .ce_n(ce_n),
    .dio_o(dio_o), .dio_oe(dio_oe), .dio_i(dio_i)
  );
  int n_chk = 0, n_fail = 0;
  logic [7:0] dev_mem [0:4095];
  logic [7:0] ref_mem [0:4095];
  int r = 0, frames = 0, f_edges = 0, f_bad = 0, cur_bad = 0, idle_bad = 0, k;
  logic [7:0] cur_cmd = 0, f_cmd = 0;
  logic [23:0] cur_addr = 0, f_addr = 0;
  logic [31:0] cur_wnib = 0, f_wnib = 0;
  logic prev_sck = 1'b0, in_frame = 1'b0;
  logic [11:0] idx;
  always @(negedge clk) begin
    if (ce_n !== 1'b0) begin
      if (ce_n === 1'b1 && sck !== 1'b0) idle_bad++;
      if (in_frame) begin
        frames++;
        f_cmd = cur_cmd;
        f_addr = cur_addr;
        f_edges = r;
        f_wnib = cur_wnib;
        f_bad = cur_bad;
      end
      in_frame = 1'b0;
      r = 0;
      cur_cmd = 0;
      cur_addr = 0;
      cur_wnib = 0;
      cur_bad = 0;
      dio_i = 4'h0;
    end else begin
      in_frame = 1'b1;
      if (sck && !prev_sck) begin
        r++;
        if (r <= 14 && dio_oe !== 1'b1) cur_bad++;
        if (r <= 8) begin
          cur_cmd = {cur_cmd[6:0], dio_o[0]};
          if (dio_o[3:1] !== 3'b000) cur_bad++;
        end else if (r <= 14) cur_addr = {cur_addr[19:0], dio_o};
        else if (cur_cmd == 8'h38) begin
          k = r - 15;
          if (dio_oe !== 1'b1) cur_bad++;
          cur_wnib = {cur_wnib[27:0], dio_o};
          idx = 12'(cur_addr + 24'(k / 2));
          if (k % 2 == 0) dev_mem[idx][7:4] = dio_o;
          else dev_mem[idx][3:0] = dio_o;
        end else if (r > 14 + D) begin
          k = r - 15 - D;
          idx = 12'(cur_addr + 24'(k / 2));
          dio_i = (k % 2 == 0) ? dev_mem[idx][7:4] : dev_mem[idx][3:0];
        end
      end
      if (cur_cmd == 8'hEB && (r > 14 || (r == 14 && !sck)) && dio_oe !== 1'b0) cur_bad++;
    end
    prev_sck = sck;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic legal_f(input logic [1:0] sz, input logic [23:0] a);
    return sz == 0 || (sz == 1 && a[0] == 1'b0) || (sz == 2 && a[1:0] == 2'b00);
  endfunction
  function automatic int edges_f(input logic we, input logic [1:0] sz);
    return 14 + (we ? 0 : D) + 2 * (1 << sz);
  endfunction
  function automatic int lat_f(input logic we, input logic [1:0] sz, input logic [23:0] a);
    return legal_f(sz, a) ? 2 * edges_f(we, sz) + 1 : 1;
  endfunction
  function automatic logic [31:0] rd_f(input logic we, input logic [1:0] sz, input logic [23:0] a);
    logic [31:0] v = '0;
    if (we || !legal_f(sz, a)) return '0;
    for (int i = 0; i < (1 << sz); i++) v[8 * (int'(a[1:0]) + i) +: 8] = ref_mem[12'(a + 24'(i))];
    return v;
  endfunction
  function automatic logic [31:0] wnib_f(input logic [31:0] wd, input logic [1:0] sz, input logic [23:0] a);
    logic [31:0] v = '0;
    for (int i = 0; i < (1 << sz); i++) v = {v[23:0], wd[8 * (int'(a[1:0]) + i) +: 8]};
    return v;
  endfunction
  task automatic do_req(input string nm, input logic we, input logic [23:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input int dly, output int lat, output logic [31:0] rd, output logic err);
    int t = 0, f0, cyc;
    while (req_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_ready"}, 32'(req_ready), 1);
    f0 = frames;
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_size = sz;
    req_wdata = wd;
    resp_ready = (dly == 0);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_resp_seen"}, 32'(resp_valid), 1);
    lat = cyc;
    rd = resp_rdata;
    err = resp_err;
    chk({nm, "_ce_n_at_resp"}, 32'(ce_n), 1);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(resp_valid), 1);
      chk({nm, "_hold_ready"}, 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, "_idle_after"}, {30'd0, resp_valid, req_ready}, 32'd1);
    if (legal_f(sz, a)) begin
      chk({nm, "_frames"}, 32'(frames), 32'(f0 + 1));
      chk({nm, "_cmd"}, 32'(f_cmd), we ? 32'h38 : 32'hEB);
      chk({nm, "_addr"}, 32'(f_addr), 32'(a));
      chk({nm, "_edges"}, 32'(f_edges), 32'(edges_f(we, sz)));
      chk({nm, "_pad_rules"}, 32'(f_bad), 0);
      if (we) begin
        chk({nm, "_wnib"}, f_wnib, wnib_f(wd, sz, a));
        for (int i = 0; i < (1 << sz); i++) ref_mem[12'(a + 24'(i))] = wd[8 * (int'(a[1:0]) + i) +: 8];
      end
    end else chk({nm, "_no_frame"}, 32'(frames), 32'(f0));
  endtask
  typedef struct {
    logic we;
    logic [23:0] a;
    logic [1:0] sz;
    logic [31:0] wd;
    int dly;
    logic err;
    logic [31:0] rd;
    int lat;
  } vec_t;
  vec_t tv [13];
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int lat, hits;
    logic [31:0] rd, e_rd;
    logic err;
    logic we;
    logic [1:0] sz;
    logic [23:0] a;
    logic [31:0] wd;
    for (int i = 0; i < 4096; i++) begin
      dev_mem[i] = 8'($urandom());
      ref_mem[i] = dev_mem[i];
    end
    tv[0] = '{1'b1, 24'h000100, 2'd2, 32'h44332211, 0, 1'b0, 32'h0, 45};
    tv[1] = '{1'b0, 24'h000100, 2'd2, 32'h0, 0, 1'b0, 32'h44332211, 57};
    tv[2] = '{1'b0, 24'h000102, 2'd0, 32'h0, 1, 1'b0, 32'h00330000, 45};
    tv[3] = '{1'b0, 24'h000001, 2'd1, 32'h0, 0, 1'b1, 32'h0, 1};
    tv[4] = '{1'b0, 24'h000000, 2'd3, 32'h0, 0, 1'b1, 32'h0, 1};
    tv[5] = '{1'b1, 24'h000102, 2'd1, 32'hBEEF0000, 0, 1'b0, 32'h0, 37};
    tv[6] = '{1'b0, 24'h000102, 2'd1, 32'h0, 2, 1'b0, 32'hBEEF0000, 49};
    tv[7] = '{1'b1, 24'h000102, 2'd2, 32'h12345678, 0, 1'b1, 32'h0, 1};
    tv[8] = '{1'b1, 24'h000103, 2'd0, 32'h5A000000, 0, 1'b0, 32'h0, 33};
    tv[9] = '{1'b0, 24'h000100, 2'd2, 32'h0, 0, 1'b0, 32'h5AEF2211, 57};
    tv[10] = '{1'b0, 24'h000103, 2'd0, 32'h0, 0, 1'b0, 32'h5A000000, 45};
    tv[11] = '{1'b1, 24'hFFFFFC, 2'd2, 32'hCAFEF00D, 0, 1'b0, 32'h0, 45};
    tv[12] = '{1'b0, 24'hFFFFFC, 2'd2, 32'h0, 0, 1'b0, 32'hCAFEF00D, 57};
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_size = '0;
    req_wdata = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pads", {28'd0, ce_n, sck, dio_oe, req_ready}, 32'b1000);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_resp", {resp_valid, resp_err, 30'd0}, 32'd0);
    chk("post_rst_rdata", resp_rdata, 32'd0);
    chk("post_rst_dio", {27'd0, dio_oe, dio_o}, 32'd0);
    for (int i = 0; i < 13; i++) begin
      do_req($sformatf("v%0d", i), tv[i].we, tv[i].a, tv[i].sz, tv[i].wd, tv[i].dly, lat, rd, err);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tv[i].err));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
    end
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 24'h000100;
    req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (45) @(negedge clk);
    chk("abort_midframe_ce", 32'(ce_n), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_pads", {26'd0, ce_n, sck, dio_oe, resp_valid, resp_err, req_ready}, 32'b100000);
    chk("abort_dio", {28'd0, dio_o}, 32'd0);
    reset = 1'b0;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) hits++;
    end
    chk("abort_no_resp", 32'(hits), 0);
    do_req("post_abort_wr", 1'b1, 24'h000201, 2'd0, 32'h0000A500, 5, lat, rd, err);
    chk("post_abort_wr_lat", 32'(lat), 33);
    chk("post_abort_wr_err", 32'(err), 0);
    do_req("post_abort_rd", 1'b0, 24'h000201, 2'd0, 32'h0, 0, lat, rd, err);
    chk("post_abort_rd_lat", 32'(lat), 45);
    chk("post_abort_rd_data", rd, 32'h0000A500);
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = 24'($urandom());
      wd = $urandom();
      e_rd = rd_f(we, sz, a);
      do_req($sformatf("r%0d", n), we, a, sz, wd, int'($urandom_range(0, 2)), lat, rd, err);
      chk($sformatf("r%0d_err", n), 32'(err), 32'(!legal_f(sz, a)));
      chk($sformatf("r%0d_lat", n), 32'(lat), 32'(lat_f(we, sz, a)));
      chk($sformatf("r%0d_rdata", n), rd, e_rd);
    end
    chk("idle_sck_low", 32'(idle_bad), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
